// File: rtl/led_ctrl_pkg.sv
// ---- led_ctrl_pkg : shared encodings, seeds and pattern step function (rev 1.0) ----
`default_nettype none

package led_ctrl_pkg;

  localparam int unsigned PRESCALE_W = 24;
  localparam int unsigned LED_W      = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [LED_W-1:0] SEED_ONEHOT = 16'h0001;
  localparam logic [LED_W-1:0] SEED_COUNT  = 16'h0000;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [LED_W-1:0] led;
    logic             dir;
  } pattern_t;

  function automatic logic [LED_W-1:0] mode_seed(input logic [1:0] mode);
    return (mode == MODE_COUNT) ? SEED_COUNT : SEED_ONEHOT;
  endfunction

  function automatic pattern_t next_pattern(input logic [1:0] mode, input pattern_t cur);
    pattern_t nxt;
    nxt = cur;
    case (mode)
      MODE_ROL: nxt.led = {cur.led[LED_W-2:0], cur.led[LED_W-1]};
      MODE_ROR: nxt.led = {cur.led[0], cur.led[LED_W-1:1]};
      MODE_BOUNCE: begin
        // Reaching an end reverses direction and steps back inward in the same update.
        if (cur.dir == DIR_LEFT) begin
          if (cur.led[LED_W-1]) begin
            nxt.led = cur.led >> 1;
            nxt.dir = DIR_RIGHT;
          end else begin
            nxt.led = cur.led << 1;
          end
        end else begin
          if (cur.led[0]) begin
            nxt.led = cur.led << 1;
            nxt.dir = DIR_LEFT;
          end else begin
            nxt.led = cur.led >> 1;
          end
        end
      end
      default: nxt.led = cur.led + LED_W'(1);
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ---- led_tick_gen : prescaler with speed-scaled terminal count (rev 1.0) ----
`default_nettype none

module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned C_MAX_COUNT = 10_000_000 - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       clear_i,
  input  logic [1:0] speed_sel_i,
  output logic       term_o
);

  localparam logic [PRESCALE_W-1:0] C_MAX = PRESCALE_W'(C_MAX_COUNT);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic [PRESCALE_W-1:0] limit;

  assign limit  = C_MAX >> speed_sel_i;
  assign term_o = enable_i & ~clear_i & (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = term_o ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
// ---- led_pattern_ctrl : 16-bit LED pattern sequencer with run/pause/step control (rev 1.0) ----
`default_nettype none

module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned C_MAX_COUNT = 10_000_000 - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step_req,
  input  logic [1:0]       mode_sel,
  input  logic [1:0]       speed_sel,
  output logic [LED_W-1:0] led_out,
  output logic             tick,
  output logic [1:0]       state_out
);

  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  logic [1:0] state_q, state_d;
  pattern_t   pat_q, pat_d;
  logic       tick_q, tick_d;
  logic       step_q;
  logic [1:0] mode_q;
  logic [1:0] speed_q;

  logic mode_chg, speed_chg, step_edge;
  logic in_run, in_pause, in_idle;
  logic pre_clear, term, do_step, do_update;

  // Assertion is immediate; release is delayed two clocks so all state leaves reset together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  assign mode_chg  = (mode_sel != mode_q);
  assign speed_chg = (speed_sel != speed_q);
  assign step_edge = step_req & ~step_q;
  assign in_run    = (state_q == ST_RUN);
  assign in_pause  = (state_q == ST_PAUSE);
  assign in_idle   = ~in_run & ~in_pause;

  assign pre_clear = mode_chg | speed_chg | in_idle | (in_pause & run);
  assign do_step   = in_pause & step_edge & ~run;
  assign do_update = ~mode_chg & (term | do_step);

  led_tick_gen #(
    .C_MAX_COUNT (C_MAX_COUNT)
  ) u_tick_gen (
    .clk         (clk),
    .rst_n       (rst_n_s),
    .enable_i    (in_run),
    .clear_i     (pre_clear),
    .speed_sel_i (speed_sel),
    .term_o      (term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run)  state_d = ST_RUN;
      ST_RUN:   if (!run) state_d = ST_PAUSE;
      ST_PAUSE: if (run)  state_d = ST_RUN;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_d  = pat_q;
    tick_d = 1'b0;
    if (mode_chg || in_idle) begin
      pat_d.led = mode_seed(mode_sel);
      pat_d.dir = DIR_LEFT;
    end else if (do_update) begin
      pat_d  = next_pattern(mode_q, pat_q);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= ST_IDLE;
      pat_q   <= '{led: SEED_ONEHOT, dir: DIR_LEFT};
      tick_q  <= 1'b0;
      step_q  <= 1'b0;
      mode_q  <= 2'd0;
      speed_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tick_q  <= tick_d;
      step_q  <= step_req;
      mode_q  <= mode_sel;
      speed_q <= speed_sel;
    end
  end

  assign led_out   = pat_q.led;
  assign tick      = tick_q;
  assign state_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
// ---- tb_led_pattern_ctrl : scoreboard bench for led_pattern_ctrl (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_led_pattern_ctrl;

  localparam int unsigned C_MAX_COUNT = 3;

  typedef struct {
    logic [15:0] led;
    int          gap;
  } want_t;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        run       = 1'b0;
  logic        step_req  = 1'b0;
  logic [1:0]  mode_sel  = 2'd0;
  logic [1:0]  speed_sel = 2'd0;
  logic [15:0] led_out;
  logic        tick;
  logic [1:0]  state_out;

  int    n_tests  = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    last_cyc = 0;
  want_t want_q[$];

  led_pattern_ctrl #(
    .C_MAX_COUNT (C_MAX_COUNT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .step_req  (step_req),
    .mode_sel  (mode_sel),
    .speed_sel (speed_sel),
    .led_out   (led_out),
    .tick      (tick),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] led, input int gap);
    want_t w;
    w.led = led;
    w.gap = gap;
    want_q.push_back(w);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every tick pulse must match the next scoreboard entry, including spacing.
  initial begin : monitor
    want_t w;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (want_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tick: led_out=%h with nothing expected (t=%0t)", led_out, $time);
        end else begin
          w = want_q.pop_front();
          check("tick_led", {16'h0, led_out}, {16'h0, w.led});
          if (w.gap != 0) check("tick_gap", cyc - last_cyc, w.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    // Reset state
    cycles(3);
    check("rst_led", {16'h0, led_out}, 32'h0001);
    check("rst_tick", {31'h0, tick}, 32'h0);
    check("rst_state", {30'h0, state_out}, 32'h0);
    reset_n = 1'b1;
    cycles(4);
    check("idle_wait_state", {30'h0, state_out}, 32'h0);
    check("idle_wait_led", {16'h0, led_out}, 32'h0001);

    // Rotate-left, 4-cycle period, including 8000 -> 0001 wrap
    push(16'h0002, 0);
    for (int k = 2; k < 16; k++) push(16'h0001 << k, 4);
    push(16'h0001, 4);
    push(16'h0002, 4);
    run = 1'b1;
    cycles(2);
    check("run_state", {30'h0, state_out}, 32'h1);
    cycles(67);
    run = 1'b0;
    cycles(3);
    check("rol_all_ticks", want_q.size(), 0);
    check("pause_state", {30'h0, state_out}, 32'h2);
    check("pause_led", {16'h0, led_out}, 32'h0002);

    // Step held high in PAUSE: exactly one update
    push(16'h0004, 0);
    step_req = 1'b1;
    cycles(5);
    step_req = 1'b0;
    cycles(3);
    check("step_once", want_q.size(), 0);
    check("step_led", {16'h0, led_out}, 32'h0004);
    check("step_state", {30'h0, state_out}, 32'h2);

    // run and step together: RUN wins, step discarded
    push(16'h0008, 0);
    run      = 1'b1;
    step_req = 1'b1;
    cycles(1);
    check("runstep_state", {30'h0, state_out}, 32'h1);
    check("runstep_tick", {31'h0, tick}, 32'h0);
    check("runstep_led", {16'h0, led_out}, 32'h0004);

    // Mode change 0->1 in the terminal-count cycle
    cycles(7);
    mode_sel = 2'd1;
    push(16'h8000, 8);
    push(16'h4000, 4);
    cycles(1);
    check("modechg_led", {16'h0, led_out}, 32'h0001);
    check("modechg_tick", {31'h0, tick}, 32'h0);
    check("modechg_state", {30'h0, state_out}, 32'h1);
    cycles(8);
    run      = 1'b0;
    step_req = 1'b0;
    cycles(3);
    check("ror_all_ticks", want_q.size(), 0);
    check("ror_led", {16'h0, led_out}, 32'h4000);

    // Bounce from 0001: 31 ticks
    mode_sel = 2'd2;
    cycles(1);
    check("bounce_seed", {16'h0, led_out}, 32'h0001);
    check("bounce_seed_tick", {31'h0, tick}, 32'h0);
    check("bounce_pause_kept", {30'h0, state_out}, 32'h2);
    for (int k = 1; k <= 31; k++) begin
      int pos;
      pos = (k <= 15) ? k : ((k <= 30) ? 30 - k : k - 30);
      push(16'h0001 << pos, (k == 1) ? 0 : 4);
    end
    run = 1'b1;
    cycles(125);
    run = 1'b0;
    cycles(3);
    check("bounce_all_ticks", want_q.size(), 0);
    check("bounce_led", {16'h0, led_out}, 32'h0002);

    // Binary count at 1-cycle period through FFFF -> 0000
    mode_sel  = 2'd3;
    speed_sel = 2'd2;
    cycles(1);
    check("count_seed", {16'h0, led_out}, 32'h0000);
    for (int k = 1; k <= 65536; k++) push(16'(k), (k == 1) ? 0 : 1);
    run = 1'b1;
    cycles(65536);
    run = 1'b0;
    cycles(3);
    check("count_all_ticks", want_q.size(), 0);
    check("count_wrap_led", {16'h0, led_out}, 32'h0000);

    // Speed change mid-count restarts the prescaler
    push(16'h0001, 0);
    push(16'h0002, 5);
    speed_sel = 2'd0;
    run       = 1'b1;
    cycles(7);
    speed_sel = 2'd1;
    cycles(3);
    run = 1'b0;
    cycles(3);
    check("speed_all_ticks", want_q.size(), 0);
    check("speed_led", {16'h0, led_out}, 32'h0002);

    // Asynchronous reset mid-RUN, between clock edges, right after a tick
    push(16'h0003, 0);
    run = 1'b1;
    cycles(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_led", {16'h0, led_out}, 32'h0001);
    check("async_rst_tick", {31'h0, tick}, 32'h0);
    check("async_rst_state", {30'h0, state_out}, 32'h0);
    run       = 1'b0;
    mode_sel  = 2'd0;
    speed_sel = 2'd0;
    cycles(3);
    reset_n = 1'b1;
    cycles(5);
    check("post_rst_state", {30'h0, state_out}, 32'h0);
    check("post_rst_led", {16'h0, led_out}, 32'h0001);
    check("post_rst_tick", {31'h0, tick}, 32'h0);
    check("final_queue_empty", want_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter C_MAX_COUNT, default 10_000_000-1: base prescaler terminal count; fits in 24 bits.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  level; 1 = advance pattern on prescaler ticks, 0 = pause.
REQ-005 step_req  in  1  single-step request; only its 0->1 edge (registered internally) is used.
REQ-006 mode_sel  in  2  pattern: 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary up-count.
REQ-007 speed_sel  in  2  tick rate: period = (C_MAX_COUNT >> speed_sel) + 1 cycles.
REQ-008 led_out  out  16  registered LED pattern.
REQ-009 tick  out  1  registered; one-cycle pulse in the cycle led_out shows a new value.
REQ-010 state_out  out  2  current FSM state encoding.

Function
REQ-011 FSM states: IDLE=0, RUN=1, PAUSE=2; encoding 3 unused; it SHALL decode to IDLE on the next cycle.
REQ-012 IDLE: prescaler held at 0, led_out held at the mode seed; run=1 -> RUN next cycle.
REQ-013 RUN: prescaler increments each cycle; at terminal count it SHALL clear to 0 and apply one pattern update next cycle; run=0 -> PAUSE.
REQ-014 PAUSE: prescaler and led_out held; run=1 -> RUN with prescaler restarting from 0.
REQ-015 PAUSE: a step_req rising edge SHALL apply exactly one pattern update, with tick=1, one cycle after the edge; step_req held high gives no further updates.
REQ-016 step_req SHALL be ignored in IDLE and RUN; if run=1 and a step edge occur in the same PAUSE cycle, the RUN transition wins and the step is discarded.
REQ-017 Mode seeds: modes 0-2 seed 16'h0001; mode 3 seeds 16'h0000.
REQ-018 Rotate-left update: {led[14:0], led[15]}; 16'h8000 wraps to 16'h0001.
REQ-019 Rotate-right update: {led[0], led[15:1]}; 16'h0001 wraps to 16'h8000.
REQ-020 Bounce: a direction flag (seed = left) moves a single lit bit; at bit15 going left, the next value is bit14 and the flag flips to right; at bit0 going right, the next value is bit1 and the flag flips to left.
REQ-021 Binary mode: led_out+1 modulo 2^16; 16'hFFFF wraps to 16'h0000.
REQ-022 A mode_sel change (registered compare) in any state SHALL, on the next cycle, reload the new seed, reset the bounce direction, clear the prescaler and suppress tick; the FSM state is unchanged.
REQ-023 A speed_sel change SHALL clear the prescaler on the next cycle; led_out is unchanged.
REQ-024 If a mode change and a terminal count or step coincide, the mode reload wins and no update or tick occurs.
REQ-025 Terminal compare SHALL use 24-bit unsigned arithmetic; with C_MAX_COUNT >> speed_sel = 0, a tick occurs every cycle.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, prescaler 0, led_out 16'h0001, tick 0, bounce direction left, registered step_req and mode_sel cleared to 0.
REQ-027 Reset asserted mid-operation SHALL abandon any pending update; after release, the block waits in IDLE until run=1.
REQ-028 Reset release SHALL be synchronised to clk before use by the sequential logic.

Structure
REQ-029 Package led_ctrl_pkg SHALL hold the state encodings, mode encodings, seed constants and the 24-bit prescaler width.
REQ-030 Sub-module led_tick_gen SHALL implement the prescaler, with inputs enable, clear and speed_sel and a one-cycle terminal pulse output.

Verification (C_MAX_COUNT=3)
REQ-031 Reset, run=1, mode 0, speed 0: led_out steps 0001->0002->0004 every 4 cycles; tick pulses once per step; 8000->0001 wraps.
REQ-032 Mode 2 from 0001, run=1: after 15 ticks led_out=8000; the next tick gives 4000; after 30 ticks total led_out=0001; the next tick gives 0002.
REQ-033 Mode 3, speed 2 (1-cycle period): tick every cycle; preload via 65535 ticks reaches FFFF; the next tick gives 0000.
REQ-034 In PAUSE, hold step_req high for 5 cycles: exactly one update and one tick; assert run and step_req together: RUN entered, no extra update.
REQ-035 In RUN, change mode 0->1 in the terminal-count cycle: led_out=0001 next cycle, no tick, next update at 4 cycles gives 8000.
REQ-036 Assert reset_n low mid-RUN, between clock edges: outputs reach reset values with no clock edge; after release with run=0, the block stays IDLE with led_out=0001.
